// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX frame arbiter.
`timescale 1ns/1ps
package uart_arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned GID_W   = $clog2(MAX_REQ);
    localparam int unsigned BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] ARB_HDR_BASE = 8'hA0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    // Source-tag byte that precedes a frame when headers are enabled.
    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [GID_W-1:0] gid);
        return ARB_HDR_BASE | BYTE_W'(gid);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer byte streams and output FIFO write port of the UART TX arbiter.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    import uart_arb_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic [BYTE_W-1:0]       fifo_din;
    logic                    fifo_wr_en;

    // Producers and FIFO side.
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_din, fifo_wr_en
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_din, fifo_wr_en
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first valid requester after last_grant, cyclically.
`timescale 1ns/1ps
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [GID_W-1:0] last_grant,
    output logic [GID_W-1:0] winner,
    output logic             any_valid
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    // Rotate so bit 0 is the requester right after last_grant, then take the lowest set bit.
    always_comb begin
        int unsigned off;
        int unsigned sum;
        dbl = {valid, valid};
        rot = N_REQ'(dbl >> (32'(last_grant) + 32'd1));
        off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = unsigned'(i);
            end
        end
        sum = 32'(last_grant) + 32'd1 + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        winner    = GID_W'(sum);
        any_valid = |valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter in front of the shared UART output FIFO.
// Optional feature macro: ARB_HDR_EN (prefix every frame with an 8'hA0|id tag byte).
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic             busy,
    output logic [GID_W-1:0] grant_id,
    output logic             frame_done,
    output logic             abort_pulse,
    output logic [CNT_W-1:0] abort_count
);

    // Watchdog holds at most TIMEOUT_CYCLES-1; the idle cycle that would reach TIMEOUT_CYCLES aborts.
    localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t        state, state_nxt;
    logic [GID_W-1:0]  grant_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic              done_nxt, abort_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [GID_W-1:0]  pick_winner;
    logic              pick_any;

    logic              sel_valid, sel_last;
    logic [BYTE_W-1:0] sel_data;

    logic [N_REQ-1:0]  ready_c;
    logic              wr_en_c;
    logic [BYTE_W-1:0] din_c;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .valid      (bus.req_valid),
        .last_grant (grant_id),
        .winner     (pick_winner),
        .any_valid  (pick_any)
    );

    // Select the granted requester's byte stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == GID_W'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Next-state, watchdog and combinational FIFO/ready pass-through.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        wd_nxt    = wd_cnt;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        cnt_nxt   = abort_count;
        ready_c   = '0;
        wr_en_c   = 1'b0;
        din_c     = '0;

        case (state)
            IDLE: begin
                wd_nxt = '0;
                if (pick_any) begin
                    grant_nxt = pick_winner;
`ifdef ARB_HDR_EN
                    state_nxt = HDR;
`else
                    state_nxt = XFER;
`endif
                end
            end

`ifdef ARB_HDR_EN
            HDR: begin
                wd_nxt  = '0;
                din_c   = hdr_byte(grant_id);
                wr_en_c = !bus.fifo_full;
                if (!bus.fifo_full) begin
                    state_nxt = XFER;
                end
            end
`endif

            XFER: begin
                for (int i = 0; i < N_REQ; i++) begin
                    ready_c[i] = (grant_id == GID_W'(i)) && !bus.fifo_full;
                end
                din_c   = sel_data;
                wr_en_c = sel_valid && !bus.fifo_full;
                if (wr_en_c) begin
                    wd_nxt = '0;
                    if (sel_last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (!sel_valid && !bus.fifo_full && (TIMEOUT_CYCLES != 0)) begin
                    if (wd_cnt == WD_LAST) begin
                        state_nxt = IDLE;
                        abort_nxt = 1'b1;
                        wd_nxt    = '0;
                        if (abort_count != '1) begin
                            cnt_nxt = abort_count + CNT_W'(1);
                        end
                    end else begin
                        wd_nxt = wd_cnt + WD_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = ready_c;
    assign bus.fifo_wr_en = wr_en_c;
    assign bus.fifo_din   = din_c;

    // State, grant, watchdog and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant_id    <= GID_W'(N_REQ - 1);
            wd_cnt      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            abort_pulse <= 1'b0;
            abort_count <= '0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            wd_cnt      <= wd_nxt;
            busy        <= (state_nxt != IDLE);
            frame_done  <= done_nxt;
            abort_pulse <= abort_nxt;
            abort_count <= cnt_nxt;
        end
    end

endmodule
